cisc_control_unit: RTL
======================

// Module: cisc_control_unit
// PURPOSE
//  Moore/Mealy sequencer that drives the 16-bit CISC datapath: register bank, ALSU, status, DR, AR, PC and IR.
//  Fetches each instruction, decodes IR[15:12], steps the datapath through the execute states, and handshakes with memory via mem_rd/mem_wr/mem_ready.
//  Adds a wait-state watchdog that halts on a stuck bus.
// PARAMETERS
//  FUN_PASS_A  4'h8  ALSU Fun code that forwards operand A unchanged
//  MAX_WAIT    15    max cycles a memory access may wait for mem_ready (watchdog)
// PORTS
//  clk          in   1   single clock; all state updates on rising edge
//  rst_n        in   1   synchronous, active-low reset
//  ir           in   16  IR register contents
//  cond         in   1   XOR2CU: selected status flag ^ NegS
//  mem_ready    in   1   memory completes read/write this cycle
//  mem_rd/mem_wr out 1   memory read / write request
//  WriteEnable  out  1   bank write;  WriteAddress/ReadAddressA/ReadAddressB out 3 each
//  WireSelect   out  1   bank input mux: 1=Datos, 0=ALSUout
//  Fun          out  4   ALSU function
//  LoadS        out  1   status load;  SelectS out 2 flag select;  NegS out 1 flag invert
//  LoadDR/SelectDR/oeDR, LoadAR/SelectAR/oeAR  out 1 each  (Select: 0=Datos, 1=ALSUout)
//  LoadPC out 1; SelectPC out 2 (0=Datos,1=ALSUout,2=Cero,3=PC+1); oePCa/oePCd out 1
//  LoadIR       out  1   IR load from Datos
//  halted       out  1   HALT state reached;  bus_err out 1 watchdog fired (sticky)
// BEHAVIOUR
//  Encoding: op=ir[15:12], rd=ir[11:9], ra=ir[8:6], rb=ir[5:3], fn=ir[2:0].
//   0 NOP | 1 ALU rd=ra fn rb | 2 LD rd=M[ra] | 3 ST M[ra]=rb | 4 JMP PC=M[PC]
//   5 BR if cond PC=ra (SelectS=ir[8:7]? no: SelectS=ir[2:1], NegS=ir[0]) | 6 LDI rd=M[PC],PC++ | F HALT | 7-E = NOP
//  Default: every output 0 unless listed. ReadAddressA/B = ra/rb, WriteAddress = rd always.
//  States:
//   RST : entered whenever rst_n=0 at an edge; LoadPC=1, SelectPC=2 -> PC=0; all other outputs 0, halted=0, bus_err=0; next FETCH.
//   FETCH: oePCa=1, mem_rd=1; on mem_ready: LoadIR=1, LoadPC=1, SelectPC=3; -> DECODE.
//   DECODE: no datapath loads; branch by op: 1->EXALU, 2/3->ADDR, 4/6->IMM, 5->BR, F->HALT, else FETCH.
//   EXALU: Fun={1'b0,fn}, WireSelect=0, WriteEnable=1, LoadS=1; -> FETCH.
//   ADDR : Fun=FUN_PASS_A, SelectAR=1, LoadAR=1; op2->MRD, op3->DRLD.
//   DRLD : ReadAddressA=rb, Fun=FUN_PASS_A, SelectDR=1, LoadDR=1; -> MWR.
//   MRD  : oeAR=1, mem_rd=1; on mem_ready: WireSelect=1, WriteEnable=1; -> FETCH.
//   MWR  : oeAR=1, oeDR=1, mem_wr=1; on mem_ready -> FETCH.
//   IMM  : oePCa=1, mem_rd=1; on mem_ready: op4: LoadPC=1,SelectPC=0; op6: WriteEnable=1,WireSelect=1,LoadPC=1,SelectPC=3; -> FETCH.
//   BR   : SelectS=ir[2:1], NegS=ir[0]; if cond: Fun=FUN_PASS_A, LoadPC=1, SelectPC=1; -> FETCH. 1 cycle.
//   HALT : halted=1, all else 0; exits only on reset.
//  Mealy rule: mem_ready-qualified loads assert in the same cycle mem_ready=1; mem_rd/mem_wr hold steady until then.
//  Watchdog: 4-bit wait counter clears on state entry; counts each cycle in FETCH/MRD/MWR/IMM with mem_ready=0;
//   reaching MAX_WAIT with mem_ready=0 -> HALT, bus_err=1. mem_ready on exactly cycle MAX_WAIT wins (no error).
//  Never assert oeDR with oePCd, nor oeAR with oePCa, in any cycle. Loads never assert in DECODE.
//  Reset mid-access: request dropped next cycle; no load issued; PC forced 0.
//  Latency (mem_ready immediate): NOP 2, ALU/BR 3, LD/JMP/LDI 3-4, ST 5 cycles.
// TESTING
//  Reset then mem_ready=1 with ir=16'h0000 -> PC 0,1,2 each 2 cycles; halted=0.
//  ir=16'h1298 (ALU r1=r2 op r3, fn=0) -> EXALU cycle: WriteEnable=1, WriteAddress=1, RA=2, RB=3, LoadS=1.
//  ST ir=16'h3080, mem_ready delayed 3 cycles -> mem_wr,oeAR,oeDR held 3 cycles, then FETCH.
//  BR with cond=0 -> no LoadPC; cond=1 -> LoadPC=1, SelectPC=1, Fun=FUN_PASS_A.
//  mem_ready held 0 in FETCH for MAX_WAIT cycles -> HALT, bus_err=1; rst_n=0 one edge clears both.
//  ir=16'hF000 -> halted=1, outputs idle for 100 cycles regardless of mem_ready.

Source files
------------

// File: rtl/cisc_control_unit.sv
// ============================================================================
// Module  : cisc_control_unit
// Brief   : Fetch/decode/execute sequencer for the 16-bit CISC datapath,
//           with a memory wait-state watchdog that halts on a stuck bus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cisc_control_unit #(
    parameter logic [3:0] FUN_PASS_A = 4'h8,
    parameter int         MAX_WAIT   = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ir,
    input  logic        cond,
    input  logic        mem_ready,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        WriteEnable,
    output logic [2:0]  WriteAddress,
    output logic [2:0]  ReadAddressA,
    output logic [2:0]  ReadAddressB,
    output logic        WireSelect,
    output logic [3:0]  Fun,
    output logic        LoadS,
    output logic [1:0]  SelectS,
    output logic        NegS,
    output logic        LoadDR,
    output logic        SelectDR,
    output logic        oeDR,
    output logic        LoadAR,
    output logic        SelectAR,
    output logic        oeAR,
    output logic        LoadPC,
    output logic [1:0]  SelectPC,
    output logic        oePCa,
    output logic        oePCd,
    output logic        LoadIR,
    output logic        halted,
    output logic        bus_err
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXALU  = 4'd3,
        S_ADDR   = 4'd4,
        S_DRLD   = 4'd5,
        S_MRD    = 4'd6,
        S_MWR    = 4'd7,
        S_IMM    = 4'd8,
        S_BR     = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    localparam logic [3:0] c_WAIT_LAST = 4'(MAX_WAIT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_wait;
    logic       r_bus_err;

    logic [3:0] w_op;
    logic [2:0] w_rd, w_ra, w_rb, w_fn;
    logic       w_wait_state;
    logic       w_timeout;

    assign w_op = ir[15:12];
    assign w_rd = ir[11:9];
    assign w_ra = ir[8:6];
    assign w_rb = ir[5:3];
    assign w_fn = ir[2:0];

    // Watchdog fires on the MAX_WAIT-th consecutive cycle without mem_ready.
    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MRD) ||
                          (r_state == S_MWR)   || (r_state == S_IMM);
    assign w_timeout    = w_wait_state && !mem_ready && (r_wait == c_WAIT_LAST);

    assign halted  = (r_state == S_HALT);
    assign bus_err = r_bus_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_RST;
            r_wait    <= 4'd0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait <= 4'd0;
            else if (w_wait_state && !mem_ready)
                r_wait <= r_wait + 4'd1;
            if (w_timeout)
                r_bus_err <= 1'b1;
        end
    end

    always_comb begin
        w_next       = r_state;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        WriteEnable  = 1'b0;
        WriteAddress = w_rd;
        ReadAddressA = w_ra;
        ReadAddressB = w_rb;
        WireSelect   = 1'b0;
        Fun          = 4'h0;
        LoadS        = 1'b0;
        SelectS      = 2'b00;
        NegS         = 1'b0;
        LoadDR       = 1'b0;
        SelectDR     = 1'b0;
        oeDR         = 1'b0;
        LoadAR       = 1'b0;
        SelectAR     = 1'b0;
        oeAR         = 1'b0;
        LoadPC       = 1'b0;
        SelectPC     = 2'd0;
        oePCa        = 1'b0;
        oePCd        = 1'b0;
        LoadIR       = 1'b0;

        case (r_state)
            S_RST: begin
                LoadPC   = 1'b1;
                SelectPC = 2'd2;
                w_next   = S_FETCH;
            end
            S_FETCH: begin
                oePCa  = 1'b1;
                mem_rd = 1'b1;
                if (mem_ready) begin
                    LoadIR   = 1'b1;
                    LoadPC   = 1'b1;
                    SelectPC = 2'd3;
                    w_next   = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_DECODE: begin
                case (w_op)
                    4'h1:       w_next = S_EXALU;
                    4'h2, 4'h3: w_next = S_ADDR;
                    4'h4, 4'h6: w_next = S_IMM;
                    4'h5:       w_next = S_BR;
                    4'hF:       w_next = S_HALT;
                    default:    w_next = S_FETCH;
                endcase
            end
            S_EXALU: begin
                Fun         = {1'b0, w_fn};
                WriteEnable = 1'b1;
                LoadS       = 1'b1;
                w_next      = S_FETCH;
            end
            S_ADDR: begin
                Fun      = FUN_PASS_A;
                SelectAR = 1'b1;
                LoadAR   = 1'b1;
                w_next   = (w_op == 4'h2) ? S_MRD : S_DRLD;
            end
            S_DRLD: begin
                ReadAddressA = w_rb;
                Fun          = FUN_PASS_A;
                SelectDR     = 1'b1;
                LoadDR       = 1'b1;
                w_next       = S_MWR;
            end
            S_MRD: begin
                oeAR   = 1'b1;
                mem_rd = 1'b1;
                if (mem_ready) begin
                    WireSelect  = 1'b1;
                    WriteEnable = 1'b1;
                    w_next      = S_FETCH;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_MWR: begin
                oeAR   = 1'b1;
                oeDR   = 1'b1;
                mem_wr = 1'b1;
                if (mem_ready)
                    w_next = S_FETCH;
                else if (w_timeout)
                    w_next = S_HALT;
            end
            S_IMM: begin
                oePCa  = 1'b1;
                mem_rd = 1'b1;
                if (mem_ready) begin
                    LoadPC = 1'b1;
                    if (w_op == 4'h6) begin
                        WriteEnable = 1'b1;
                        WireSelect  = 1'b1;
                        SelectPC    = 2'd3;
                    end
                    w_next = S_FETCH;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_BR: begin
                SelectS = w_fn[2:1];
                NegS    = w_fn[0];
                if (cond) begin
                    Fun      = FUN_PASS_A;
                    LoadPC   = 1'b1;
                    SelectPC = 2'd1;
                end
                w_next = S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_RST;
            end
        endcase
    end

endmodule

`default_nettype wire
